// File: rtl/mux_arb_pipe.sv
// N:1 valid/ready multiplexer with a one-entry registered output stage.
// Mode 0 routes the channel chosen by sel. Mode 1 arbitrates round-robin
// among the valid channels. The optional MUX_ARB_SEL_ERR_EN define adds a
// sticky sel_err flag for an out-of-range directed select.

module mux_arb_pipe #(
  parameter int unsigned NUM_IN = 31,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef MUX_ARB_SEL_ERR_EN
  output logic                     sel_err,
`endif
  output logic [SEL_W-1:0]         out_src
);

  localparam logic [SEL_W:0]   NumInW = NUM_IN[SEL_W:0];
  localparam logic [SEL_W-1:0] RrInit = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0]  rr_last_q, rr_last_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d;
  logic [SEL_W-1:0]  out_src_d;

  logic              can_load;
  logic              sel_ok;
  logic [NUM_IN-1:0] hi_mask;
  logic [NUM_IN-1:0] masked_valid;
  logic              rr_found;
  logic [SEL_W-1:0]  rr_idx;
  logic              grant_any;
  logic [SEL_W-1:0]  grant_idx;
  logic [NUM_IN-1:0] grant;
  logic [DATA_W-1:0] grant_data;
  logic              accept;

  assign can_load = ~out_valid | out_ready;
  assign sel_ok   = {1'b0, sel} < NumInW;

  // Round-robin: lowest valid above rr_last first, otherwise wrap to lowest valid.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      hi_mask[i] = SEL_W'(i) > rr_last_q;
    end
    masked_valid = in_valid & hi_mask;
    rr_found     = |in_valid;
    rr_idx       = '0;
    if (|masked_valid) begin
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (masked_valid[i]) rr_idx = SEL_W'(i);
      end
    end else begin
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (in_valid[i]) rr_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    grant_any = mode ? rr_found : sel_ok;
    grant_idx = mode ? rr_idx : sel;
    grant     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      grant[i] = grant_any && (grant_idx == SEL_W'(i));
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) grant_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign in_ready = grant & {NUM_IN{can_load}};
  assign accept   = (|(grant & in_valid)) & can_load;

  always_comb begin
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_src_d   = out_src;
    rr_last_d   = rr_last_q;
    if (accept) begin
      out_data_d  = grant_data;
      out_valid_d = 1'b1;
      out_src_d   = grant_idx;
      if (mode) rr_last_d = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_src   <= '0;
      rr_last_q <= RrInit;
    end else begin
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_src   <= out_src_d;
      rr_last_q <= rr_last_d;
    end
  end

`ifdef MUX_ARB_SEL_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (!mode && !sel_ok && (|in_valid)) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule
